// File: rtl/counter_ctrl_pkg.sv
// Shared encodings for the counter sequencer: command opcodes, FSM states and default widths.
package counter_pkg;

  localparam int WIDTH   = 8;
  localparam int PRESC_W = 8;

  typedef enum logic [1:0] {
    OP_STOP  = 2'b00,
    OP_START = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/counter_ctrl_if.sv
// Host command port for counter_ctrl: valid/ready handshake carrying an opcode and a data word.
interface counter_ctrl_if #(parameter int WIDTH = 8);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;

  modport master (output cmd_valid, cmd_op, cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_data, output cmd_ready);
endinterface

// File: rtl/counter_prescaler.sv
// Prescaler for the count datapath: emits a tick every presc+1 enabled cycles.
module counter_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic               clr_i,
  input  logic [PRESC_W-1:0] presc_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] psc_q, psc_d;

  // >= rather than == so a lowered presc takes effect on the next enabled cycle.
  assign tick_o = en_i & (psc_q >= presc_i);

  always_comb begin
    psc_d = psc_q;
    if (clr_i)     psc_d = '0;
    else if (en_i) psc_d = tick_o ? '0 : psc_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) psc_q <= '0;
    else        psc_q <= psc_d;
  end

endmodule

// File: rtl/counter_ctrl.sv
// Command-driven run/stop sequencer for the wrap counter with limit, prescaler and one-shot mode.
// state  | meaning
// S_IDLE | stopped, count holds, commands accepted
// S_RUN  | prescaler running, count advances on ticks
// S_DONE | one-shot completed, single cycle, commands refused
module counter_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH   = counter_pkg::WIDTH,
  parameter int PRESC_W = counter_pkg::PRESC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  counter_ctrl_if.slave      cmd,
  input  logic               mode_oneshot_i,
  input  logic [PRESC_W-1:0] presc_i,
  output logic [WIDTH-1:0]   count_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               wrap_o
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic             ready;
  logic             accept;
  cmd_op_e          op;
  logic             psc_en, psc_clr, tick_raw, tick, term_tick;

  assign op       = cmd_op_e'(cmd.cmd_op);
  assign accept   = cmd.cmd_valid & ready;
  assign psc_en   = (state_q == S_RUN) & ~(accept & (op == OP_STOP));
  assign psc_clr  = accept & ((op == OP_CLEAR) | ((op == OP_START) & (state_q == S_IDLE)));
  // An accepted command swallows a coincident tick completely.
  assign tick      = tick_raw & ~accept;
  assign term_tick = tick & (count_q >= limit_q);

  counter_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (psc_en),
    .clr_i   (psc_clr),
    .presc_i (presc_i),
    .tick_o  (tick_raw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept && op == OP_START) state_d = S_RUN;
      S_RUN: begin
        if (accept && op == OP_STOP)           state_d = S_IDLE;
        else if (term_tick && mode_oneshot_i)  state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready  = (state_q != S_DONE);
    busy_o = (state_q == S_RUN);
  end

  assign cmd.cmd_ready = ready;

  always_comb begin
    count_d = count_q;
    limit_d = limit_q;
    done_d  = term_tick & mode_oneshot_i;
    wrap_d  = term_tick & ~mode_oneshot_i;
    if (accept && op == OP_LOAD)  limit_d = cmd.cmd_data;
    if (accept && op == OP_CLEAR) count_d = '0;
    else if (tick) begin
      if (count_q < limit_q)     count_d = count_q + 1'b1;
      else if (!mode_oneshot_i)  count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      limit_q <= '1;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      limit_q <= limit_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count_o = count_q;
  assign done_o  = done_q;
  assign wrap_o  = wrap_q;

endmodule
